// File: rtl/page_walker_pkg.sv
// page_walker_pkg: shared widths, state encoding and translation cache entry type.
// Rev 1.0
`default_nettype none

package page_walker_pkg;

  localparam int OFFSET_W    = 12;
  localparam int PT_IDX_W    = 10;
  localparam int PD_IDX_W    = 10;
  localparam int VPN_W       = 20;
  localparam int PPN_W       = 20;
  localparam int PRESENT_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_L1_REQ = 3'd1,
    S_L1_CHK = 3'd2,
    S_L2_REQ = 3'd3,
    S_L2_CHK = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
  } tlb_entry_t;

endpackage

`default_nettype wire

// File: rtl/page_walker_tlb.sv
// page_walker_tlb: fully-associative VPN->PPN cache with round-robin replacement.
// Rev 1.0
`default_nettype none

module page_walker_tlb
  import page_walker_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [VPN_W-1:0] lookup_vpn,
  output logic             lookup_hit,
  output logic [PPN_W-1:0] lookup_ppn,
  input  logic             fill_en,
  input  logic [VPN_W-1:0] fill_vpn,
  input  logic [PPN_W-1:0] fill_ppn
);

  localparam int PTR_W = $clog2(ENTRIES);

  tlb_entry_t       entries [ENTRIES];
  logic [PTR_W-1:0] ptr;

  // Flush has priority over a fill arriving on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i] <= '0;
      end
      ptr <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else if (fill_en) begin
      entries[ptr] <= '{valid: 1'b1, vpn: fill_vpn, ppn: fill_ppn};
      ptr          <= ptr + 1'b1;
    end
  end

  always_comb begin
    lookup_hit = 1'b0;
    lookup_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (entries[i].valid && (entries[i].vpn == lookup_vpn)) begin
        lookup_hit = 1'b1;
        lookup_ppn = entries[i].ppn;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/page_walker.sv
// page_walker: two-level page-table walker with a small translation cache.
// Rev 1.0
`default_nettype none

module page_walker
  import page_walker_pkg::*;
#(
  parameter int TLB_ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ptbr,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_vaddr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_paddr,
  output logic        resp_fault,
  output logic        resp_hit,
  output logic [29:0] ram_addr,
  output logic        ram_read_en,
  input  logic [31:0] ram_rdata
);

  state_t      state;
  logic [31:0] vaddr_q;
  logic        flush_seen;
  logic        tlb_hit;
  logic [PPN_W-1:0] tlb_ppn;
  logic        fill_en;
  logic        entry_present;
  logic        unused_bits;

  assign req_ready     = (state == S_IDLE) && !rst;
  assign entry_present = ram_rdata[PRESENT_BIT];
  assign unused_bits   = ^{ptbr[OFFSET_W-1:0], ram_rdata[OFFSET_W-1:1]};

  // Any flush seen since accept suppresses this walk's fill.
  assign fill_en = (state == S_L2_CHK) && entry_present && !flush_seen && !flush;

  page_walker_tlb #(
    .ENTRIES(TLB_ENTRIES)
  ) u_tlb (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .lookup_vpn(req_vaddr[31:OFFSET_W]),
    .lookup_hit(tlb_hit),
    .lookup_ppn(tlb_ppn),
    .fill_en   (fill_en),
    .fill_vpn  (vaddr_q[31:OFFSET_W]),
    .fill_ppn  (ram_rdata[31:OFFSET_W])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      vaddr_q     <= '0;
      flush_seen  <= 1'b0;
      resp_valid  <= 1'b0;
      resp_paddr  <= '0;
      resp_fault  <= 1'b0;
      resp_hit    <= 1'b0;
      ram_read_en <= 1'b0;
      ram_addr    <= '0;
    end else begin
      if (flush) begin
        flush_seen <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            vaddr_q    <= req_vaddr;
            flush_seen <= flush;
            if (tlb_hit) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_paddr <= {tlb_ppn, req_vaddr[OFFSET_W-1:0]};
              resp_fault <= 1'b0;
              resp_hit   <= 1'b1;
            end else begin
              state       <= S_L1_REQ;
              ram_read_en <= 1'b1;
              ram_addr    <= {ptbr[31:OFFSET_W], req_vaddr[31:32-PD_IDX_W]};
            end
          end
        end
        S_L1_REQ: begin
          ram_read_en <= 1'b0;
          state       <= S_L1_CHK;
        end
        S_L1_CHK: begin
          if (entry_present) begin
            state       <= S_L2_REQ;
            ram_read_en <= 1'b1;
            ram_addr    <= {ram_rdata[31:OFFSET_W], vaddr_q[OFFSET_W+PT_IDX_W-1:OFFSET_W]};
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_paddr <= '0;
            resp_fault <= 1'b1;
            resp_hit   <= 1'b0;
          end
        end
        S_L2_REQ: begin
          ram_read_en <= 1'b0;
          state       <= S_L2_CHK;
        end
        S_L2_CHK: begin
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_hit   <= 1'b0;
          if (entry_present) begin
            resp_paddr <= {ram_rdata[31:OFFSET_W], vaddr_q[OFFSET_W-1:0]};
            resp_fault <= 1'b0;
          end else begin
            resp_paddr <= '0;
            resp_fault <= 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/page_walker.md
PAGE_WALKER -- requirements
Module: page_walker

Interface
REQ-001 Parameter: TLB_ENTRIES, 4, number of fully-associative translation cache entries (power of two, 2..16).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ptbr  input  32  page-directory base physical byte address; bits [11:0] ignored.
REQ-005 flush  input  1  invalidate all translation cache entries.
REQ-006 req_valid  input  1  translation request present.
REQ-007 req_ready  output  1  walker accepts a request this cycle.
REQ-008 req_vaddr  input  32  virtual byte address.
REQ-009 resp_valid  output  1  translation result present.
REQ-010 resp_ready  input  1  consumer takes result this cycle.
REQ-011 resp_paddr  output  32  physical byte address; 0 when resp_fault=1.
REQ-012 resp_fault  output  1  translation failed (non-present PDE or PTE).
REQ-013 resp_hit  output  1  result served from translation cache.
REQ-014 ram_addr  output  30  word address to the RAM.
REQ-015 ram_read_en  output  1  RAM read strobe; RAM returns data one cycle later.
REQ-016 ram_rdata  input  32  RAM read data.

Function
REQ-017 Address split: vaddr[31:22] PD index, [21:12] PT index, [11:0] offset; VPN = vaddr[31:12].
REQ-018 PDE word address = {ptbr[31:12], PD index}; PTE word address = {PDE[31:12], PT index}; paddr = {PTE[31:12], offset}.
REQ-019 Entry present bit is bit 0; all other low bits ignored.
REQ-020 States: IDLE, L1_REQ, L1_CHK, L2_REQ, L2_CHK, RESP.
REQ-021 req_ready = 1 only in IDLE with rst low; accept = req_valid & req_ready; vaddr and ptbr latched on accept.
REQ-022 Accept with cache hit on VPN -> RESP next cycle, resp_hit=1, no RAM read.
REQ-023 Accept with miss -> L1_REQ: ram_read_en=1, ram_addr=PDE address, one cycle.
REQ-024 L1_CHK: PDE present -> L2_REQ; not present -> RESP with fault.
REQ-025 L2_REQ: ram_read_en=1, ram_addr=PTE address, one cycle; L2_CHK: PTE present -> RESP with paddr, else RESP with fault.
REQ-026 Latencies from accepting edge to resp_valid: hit 1 cycle, PDE fault 3, PTE fault or successful walk 5.
REQ-027 ram_read_en is 0 in all states other than L1_REQ/L2_REQ; walker never writes RAM.
REQ-028 RESP holds resp_* stable until resp_valid & resp_ready, then IDLE; next request acceptable the cycle after.
REQ-029 Successful walk fills cache entry at round-robin pointer (VPN, PPN), pointer increments modulo TLB_ENTRIES; faults never fill.
REQ-030 flush clears all valid bits next edge; flush in same cycle as a fill drops the fill; flush asserted anywhere during a walk also drops that walk's fill, result still returned.
REQ-031 ptbr changes after accept do not affect the in-flight walk.

Reset
REQ-032 rst high for one edge: state IDLE, all cache valid bits 0, round-robin pointer 0, resp_valid 0, resp_paddr 0, resp_fault 0, resp_hit 0, ram_read_en 0, ram_addr 0.
REQ-033 rst mid-walk or in RESP abandons the transaction with no response and no fill; RAM data returning after reset is ignored.

Structure
REQ-034 Package page_walker_pkg holds index/offset widths, PRESENT bit position, state enum, cache entry struct.
REQ-035 Translation cache is sub-module page_walker_tlb (lookup, fill, flush, round-robin pointer).

Verification
REQ-036 RAM[0]=0x00001001, RAM[0x400]=0x00002001, ptbr=0, vaddr 0x00000ABC -> reads at word 0x000 then 0x400, paddr 0x00002ABC, fault 0, hit 0, latency 5.
REQ-037 Repeat 0x00000ABC -> paddr 0x00002ABC, hit 1, latency 1, ram_read_en never asserted.
REQ-038 vaddr 0x00400000 (RAM[1]=0) -> fault 1, paddr 0, one RAM read, latency 3; vaddr 0x00001000 (RAM[0x401]=0) -> fault 1, latency 5, no fill.
REQ-039 Five distinct valid VPNs walked, then first VPN -> miss (evicted); flush then 0x00000ABC -> full walk again.
REQ-040 resp_ready low 3 cycles -> resp_* stable, req_ready 0; rst asserted in L2_CHK -> no response, IDLE, cache empty.
